vote_display_ctrl: RTL and testbench
====================================

Name: vote_display_ctrl

Overview:
- Parametrised next-generation display and mode controller for the voting machine; sits between the per-candidate vote counters and the LED bank.
- Vote mode (mode=0): after each accepted vote, shows a timed all-ones confirmation pattern on the LEDs.
- Result mode (mode=1): shows the count for the candidate whose button is pressed.
- New in this generation: generalised candidate count and width, a sequential winner/tie scan, and a winner-display request.

Parameters:
- N_CAND, 4, number of candidates (2..16).
- CNT_W, 8, vote-count width; also the LED width.
- CONFIRM_CYCLES, 10, cycles the confirmation pattern is held (1..2^16-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high; all state cleared immediately.
- mode  in  1  0 = vote mode, 1 = result mode.
- valid_vote_casted  in  1  one-cycle pulse from the vote logger.
- cand_votes  in  N_CAND*CNT_W  packed counts; candidate i occupies bits [i*CNT_W +: CNT_W]. Upstream holds these stable while mode=1.
- cand_button  in  N_CAND  debounced, level-held candidate buttons.
- show_winner  in  1  level request to display the winner count.
- leds  out  CNT_W  LED bank.
- sel_idx  out  IDX_W  index currently shown on leds.
- winner_idx  out  IDX_W  lowest index holding the maximum count.
- tie  out  1  maximum count is held by two or more candidates.
- winner_valid  out  1  winner_idx and tie are valid.
- busy  out  1  winner scan in progress.

Behaviour:
- Reset:
  - leds=0, sel_idx=0, winner_idx=0, tie=0, winner_valid=0, busy=0.
  - FSM=V_IDLE; confirm counter=0; scan registers cleared.
- FSM states: V_IDLE, V_CONFIRM, R_SCAN, R_HOLD. All outputs are registered.
- V_IDLE (mode=0):
  - leds=0.
  - valid_vote_casted=1 -> V_CONFIRM, counter=CONFIRM_CYCLES.
  - mode=1 -> R_SCAN.
- V_CONFIRM:
  - leds=all ones, starting on the cycle after the pulse edge; counter decrements each cycle.
  - Counter==1 and no new pulse -> V_IDLE, leds=0 on that edge. The pattern is therefore held exactly CONFIRM_CYCLES cycles.
  - New valid_vote_casted while in V_CONFIRM -> counter reloads to CONFIRM_CYCLES; the pattern is extended, not toggled.
  - mode=1 -> abort the confirmation; leds=0 at the next edge; go to R_SCAN.
- R_SCAN:
  - busy=1, winner_valid=0. One candidate per cycle, index 0..N_CAND-1.
  - Running max uses strict greater-than, so the lowest index wins ties.
  - tie is set when a later candidate equals the running max; it is cleared when a strictly greater candidate appears.
  - After N_CAND cycles -> R_HOLD, winner_valid=1, busy=0 on the same edge.
- R_HOLD: winner results are held until mode=0.
- Display in R_SCAN and R_HOLD (one-cycle latency):
  - Any cand_button bit set -> leds=count of the lowest set index; sel_idx=that index. Lowest index wins on multiple presses.
  - Else show_winner=1 and winner_valid=1 -> leds=max count, sel_idx=winner_idx.
  - Else show_winner=1 and winner_valid=0 -> leds unchanged.
  - Otherwise leds hold their last value.
- valid_vote_casted is ignored while mode=1.
- mode 1->0 in any result state -> V_IDLE at the next edge; leds=0, winner_valid=0, tie=0, busy=0. A scan in progress is discarded.
- A mode toggle of 0->1->0 shorter than the scan leaves winner_valid=0.
- Asynchronous reset asserted mid-scan or mid-confirm: outputs reach their reset values immediately, with no completion of the operation.
- Width rules: IDX_W=max(1,$clog2(N_CAND)). Counts are compared unsigned at CNT_W bits with no extension. The confirm counter is 16 bits.

Decomposition:
- Shared package vote_pkg: FSM state enum; IDX_W function; CONFIRM_W=16 constant.
- Sub-module vote_max_scan: sequential argmax/tie engine with start, abort, idx, done, max_val, winner_idx and tie. The top module owns the FSM, confirm counter and display mux.

Test Plan:
1. Reset, mode=0, pulse valid_vote_casted at cycle 5 -> leds=8'hFF on cycles 6..15; leds=8'h00 at cycle 16; winner_valid=0 throughout.
2. Pulse at cycle 5, second pulse at cycle 12 -> leds=8'hFF on cycles 6..22; leds=0 at cycle 23.
3. Counts {3,9,4,9}, mode 0->1 -> busy=1 for 4 cycles; then winner_valid=1, winner_idx=1, tie=1; show_winner -> leds=9, sel_idx=1.
4. Counts {2,7,5,1}, mode=1, buttons 4'b1100 held -> leds=5, sel_idx=2 one cycle later; release and press 4'b0001 -> leds=2.
5. mode=1 and drop mode at scan cycle 2 -> winner_valid remains 0, leds=0, busy=0. Assert reset mid-confirm -> leds=0 immediately, without waiting for a clock edge.
6. N_CAND=8, CNT_W=12, counts all 12'h0FF -> winner_idx=0, tie=1; a button for candidate 7 -> leds=12'h0FF, sel_idx=7.

Source files
------------

// File: rtl/vote_pkg.sv
// Shared types and constants for the voting-machine display controller.
// Provides the FSM state enum, the index-width helper and the confirm-counter width.
package vote_pkg;

    localparam int CONFIRM_W = 16;

    typedef enum logic [1:0] {
        V_IDLE,
        V_CONFIRM,
        R_SCAN,
        R_HOLD
    } state_t;

    // Width needed to index n candidates, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/vote_display_ctrl_max_scan.sv
// Sequential argmax/tie engine: examines one candidate count per cycle.
// Ports: i_start/i_abort control, o_idx selects the count fed back on i_val,
// o_done marks the final candidate, o_max_val/o_winner_idx/o_tie hold results.
module vote_max_scan
    import vote_pkg::*;
#(
    parameter int  N_CAND = 4,
    parameter int  CNT_W  = 8,
    localparam int IDX_W  = idx_w(N_CAND)
)(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [CNT_W-1:0] i_val,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_done,
    output logic [CNT_W-1:0] o_max_val,
    output logic [IDX_W-1:0] o_winner_idx,
    output logic             o_tie
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_CAND - 1);

    logic             r_active;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_widx;
    logic [CNT_W-1:0] r_max;
    logic             r_tie;
    logic             w_done;

    assign w_done       = r_active && (r_idx == LAST);
    assign o_done       = w_done;
    assign o_idx        = r_idx;
    assign o_max_val    = r_max;
    assign o_winner_idx = r_widx;
    assign o_tie        = r_tie;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= 1'b0;
            r_idx    <= '0;
            r_widx   <= '0;
            r_max    <= '0;
            r_tie    <= 1'b0;
        end else if (i_abort || i_start) begin
            r_active <= i_start && !i_abort;
            r_idx    <= '0;
            r_widx   <= '0;
            r_max    <= '0;
            r_tie    <= 1'b0;
        end else if (r_active) begin
            // Candidate 0 seeds the running max so an all-zero
            // first count is not mistaken for a tie.
            if (r_idx == '0) begin
                r_max  <= i_val;
                r_widx <= '0;
                r_tie  <= 1'b0;
            end else if (i_val > r_max) begin
                r_max  <= i_val;
                r_widx <= r_idx;
                r_tie  <= 1'b0;
            end else if (i_val == r_max) begin
                r_tie  <= 1'b1;
            end
            if (w_done)
                r_active <= 1'b0;
            else
                r_idx <= r_idx + IDX_W'(1);
        end
    end

endmodule

// File: rtl/vote_display_ctrl.sv
// Display/mode controller between the vote counters and the LED bank.
// Ports: clk/reset, mode, valid_vote_casted, cand_votes, cand_button, show_winner
// in; leds, sel_idx, winner_idx, tie, winner_valid, busy out (all registered).
module vote_display_ctrl
    import vote_pkg::*;
#(
    parameter int  N_CAND         = 4,
    parameter int  CNT_W          = 8,
    parameter int  CONFIRM_CYCLES = 10,
    localparam int IDX_W          = idx_w(N_CAND)
)(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    mode,
    input  logic                    valid_vote_casted,
    input  logic [N_CAND*CNT_W-1:0] cand_votes,
    input  logic [N_CAND-1:0]       cand_button,
    input  logic                    show_winner,
    output logic [CNT_W-1:0]        leds,
    output logic [IDX_W-1:0]        sel_idx,
    output logic [IDX_W-1:0]        winner_idx,
    output logic                    tie,
    output logic                    winner_valid,
    output logic                    busy
);

    localparam logic [CONFIRM_W-1:0] C_LOAD = CONFIRM_W'(CONFIRM_CYCLES);
    localparam logic [CONFIRM_W-1:0] C_ONE  = CONFIRM_W'(1);

    state_t               r_state, w_state_nxt;
    logic [CONFIRM_W-1:0] r_cnt, w_cnt_nxt;
    logic [CNT_W-1:0]     r_leds, w_leds_nxt;
    logic [IDX_W-1:0]     r_sel, w_sel_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_wv, w_wv_nxt;

    logic                 w_result, w_start, w_abort, w_done;
    logic                 w_btn_any;
    logic [IDX_W-1:0]     w_btn_idx, w_scan_idx, w_winner_idx;
    logic [CNT_W-1:0]     w_btn_val, w_scan_val, w_max_val;
    logic                 w_tie;

    assign w_result = (r_state == R_SCAN) || (r_state == R_HOLD);
    assign w_start  = !w_result && mode;
    assign w_abort  = w_result && !mode;

    // Lowest pressed button wins.
    always_comb begin
        w_btn_any = |cand_button;
        w_btn_idx = '0;
        for (int i = N_CAND - 1; i >= 0; i--)
            if (cand_button[i]) w_btn_idx = IDX_W'(i);
    end

    always_comb begin
        w_btn_val  = '0;
        w_scan_val = '0;
        for (int i = 0; i < N_CAND; i++) begin
            if (w_btn_idx == IDX_W'(i))
                w_btn_val = cand_votes[i*CNT_W +: CNT_W];
            if (w_scan_idx == IDX_W'(i))
                w_scan_val = cand_votes[i*CNT_W +: CNT_W];
        end
    end

    vote_max_scan #(
        .N_CAND (N_CAND),
        .CNT_W  (CNT_W)
    ) u_scan (
        .clk          (clk),
        .reset        (reset),
        .i_start      (w_start),
        .i_abort      (w_abort),
        .i_val        (w_scan_val),
        .o_idx        (w_scan_idx),
        .o_done       (w_done),
        .o_max_val    (w_max_val),
        .o_winner_idx (w_winner_idx),
        .o_tie        (w_tie)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= V_IDLE;
            r_cnt   <= '0;
            r_leds  <= '0;
            r_sel   <= '0;
            r_busy  <= 1'b0;
            r_wv    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_leds  <= w_leds_nxt;
            r_sel   <= w_sel_nxt;
            r_busy  <= w_busy_nxt;
            r_wv    <= w_wv_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            V_IDLE: begin
                if (mode)                   w_state_nxt = R_SCAN;
                else if (valid_vote_casted) w_state_nxt = V_CONFIRM;
            end
            V_CONFIRM: begin
                if (mode)
                    w_state_nxt = R_SCAN;
                else if (!valid_vote_casted && r_cnt == C_ONE)
                    w_state_nxt = V_IDLE;
            end
            R_SCAN: begin
                if (!mode)       w_state_nxt = V_IDLE;
                else if (w_done) w_state_nxt = R_HOLD;
            end
            R_HOLD: begin
                if (!mode) w_state_nxt = V_IDLE;
            end
            default: w_state_nxt = V_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_leds_nxt = r_leds;
        w_sel_nxt  = r_sel;
        w_busy_nxt = r_busy;
        w_wv_nxt   = r_wv;
        unique case (r_state)
            V_IDLE: begin
                w_leds_nxt = '0;
                if (mode) begin
                    w_busy_nxt = 1'b1;
                    w_wv_nxt   = 1'b0;
                end else if (valid_vote_casted) begin
                    w_cnt_nxt  = C_LOAD;
                    w_leds_nxt = '1;
                end
            end
            V_CONFIRM: begin
                if (mode) begin
                    w_cnt_nxt  = '0;
                    w_leds_nxt = '0;
                    w_busy_nxt = 1'b1;
                    w_wv_nxt   = 1'b0;
                end else if (valid_vote_casted) begin
                    w_cnt_nxt = C_LOAD;
                end else if (r_cnt == C_ONE) begin
                    w_cnt_nxt  = '0;
                    w_leds_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt - C_ONE;
                end
            end
            R_SCAN, R_HOLD: begin
                if (!mode) begin
                    w_leds_nxt = '0;
                    w_busy_nxt = 1'b0;
                    w_wv_nxt   = 1'b0;
                end else begin
                    if (w_done) begin
                        w_busy_nxt = 1'b0;
                        w_wv_nxt   = 1'b1;
                    end
                    // Winner display needs a finished scan; otherwise hold.
                    if (w_btn_any) begin
                        w_leds_nxt = w_btn_val;
                        w_sel_nxt  = w_btn_idx;
                    end else if (show_winner && r_wv) begin
                        w_leds_nxt = w_max_val;
                        w_sel_nxt  = w_winner_idx;
                    end
                end
            end
            default: w_leds_nxt = '0;
        endcase
    end

    assign leds         = r_leds;
    assign sel_idx      = r_sel;
    assign winner_idx   = w_winner_idx;
    assign tie          = w_tie;
    assign winner_valid = r_wv;
    assign busy         = r_busy;

endmodule

// File: tb/tb_vote_display_ctrl.sv
// Self-checking bench for vote_display_ctrl: a default 4x8 instance and
// an 8x12 instance, randomized stimulus against a behavioural model.
module tb_vote_display_ctrl;

    localparam int C4 = 10;
    localparam int C8 = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic        m4 = 0, v4 = 0, sw4 = 0;
    logic [31:0] votes4 = '0;
    logic [3:0]  btn4 = '0;
    logic [7:0]  leds4;
    logic [1:0]  sel4, widx4;
    logic        tie4, wv4, busy4;

    logic        m8 = 0, v8 = 0, sw8 = 0;
    logic [95:0] votes8 = '0;
    logic [7:0]  btn8 = '0;
    logic [11:0] leds8;
    logic [2:0]  sel8, widx8;
    logic        tie8, wv8, busy8;

    int n_cmp = 0;
    int n_bad = 0;
    int mc4[$];
    int mc8[$];

    vote_display_ctrl #(
        .N_CAND(4), .CNT_W(8), .CONFIRM_CYCLES(C4)
    ) dut4 (
        .clk(clk), .reset(reset), .mode(m4),
        .valid_vote_casted(v4), .cand_votes(votes4),
        .cand_button(btn4), .show_winner(sw4),
        .leds(leds4), .sel_idx(sel4), .winner_idx(widx4),
        .tie(tie4), .winner_valid(wv4), .busy(busy4)
    );

    vote_display_ctrl #(
        .N_CAND(8), .CNT_W(12), .CONFIRM_CYCLES(C8)
    ) dut8 (
        .clk(clk), .reset(reset), .mode(m8),
        .valid_vote_casted(v8), .cand_votes(votes8),
        .cand_button(btn8), .show_winner(sw8),
        .leds(leds8), .sel_idx(sel8), .winner_idx(widx8),
        .tie(tie8), .winner_valid(wv8), .busy(busy8)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load4();
        for (int i = 0; i < 4; i++) votes4[i*8 +: 8] = 8'(mc4[i]);
    endtask

    task automatic load8();
        for (int i = 0; i < 8; i++) votes8[i*12 +: 12] = 12'(mc8[i]);
    endtask

    // Winner = lowest index holding the maximum; tie = max held twice or more.
    function automatic void ref_scan(input int v[$], output int mx,
                                     output int wi, output bit t);
        int n;
        mx = 0;
        foreach (v[i]) if (v[i] > mx) mx = v[i];
        wi = -1;
        n  = 0;
        foreach (v[i]) if (v[i] == mx) begin
            if (wi < 0) wi = i;
            n++;
        end
        t = (n >= 2);
    endfunction

    function automatic int low_bit(input int b);
        for (int i = 0; i < 16; i++) if (b[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_cmp++;
        if (leds4 !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_leds4 got=%h need=00", leds4);
        end
        n_cmp++;
        if ({sel4, widx4} !== 4'h0) begin
            n_bad++;
            $display("FAIL reset_idx4 got=%h need=0", {sel4, widx4});
        end
        n_cmp++;
        if ({tie4, wv4, busy4} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_flags4 got=%b need=000", {tie4, wv4, busy4});
        end
        n_cmp++;
        if ({leds8, sel8, widx8, tie8, wv8, busy8} !== '0) begin
            n_bad++;
            $display("FAIL reset_dut8 leds=%h sel=%0d need all zero", leds8, sel8);
        end
        reset = 1'b0;
        step();
    endtask

    // Pattern is on at cycle t iff some pulse p satisfies t-C4 <= p <= t-1.
    task automatic vote_run(input int ncyc, input int p1, input int p2,
                            input int pct);
        int last;
        bit on;
        last = -1000;
        for (int t = 0; t < ncyc; t++) begin
            v4 = (t == p1) || (t == p2) ||
                 (pct > 0 && $urandom_range(0, 99) < pct);
            if (v4) last = t;
            step();
            v4 = 1'b0;
            on = ((t + 1 - last) <= C4);
            n_cmp++;
            if (leds4 !== (on ? 8'hFF : 8'h00) || wv4 !== 1'b0) begin
                n_bad++;
                $display("FAIL confirm cyc=%0d leds=%h wv=%b need leds=%h wv=0",
                         t + 1, leds4, wv4, on ? 8'hFF : 8'h00);
            end
        end
        repeat (C4 + 1) step();
    endtask

    task automatic test_confirm();
        vote_run(20, 5, -1, 0);
        vote_run(30, 5, 12, 0);
        vote_run(80, -1, -1, 15);
    endtask

    task automatic test_scan_fixed();
        mc4 = '{3, 9, 4, 9};
        load4();
        m4 = 1'b1;
        step();
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (busy4 !== 1'b1 || wv4 !== 1'b0) begin
                n_bad++;
                $display("FAIL scan_busy k=%0d busy=%b wv=%b need 1/0",
                         k, busy4, wv4);
            end
            step();
        end
        n_cmp++;
        if (busy4 !== 1'b0 || wv4 !== 1'b1 || widx4 !== 2'd1 || tie4 !== 1'b1) begin
            n_bad++;
            $display("FAIL scan_result busy=%b wv=%b widx=%0d tie=%b need 0/1/1/1",
                     busy4, wv4, widx4, tie4);
        end
        sw4 = 1'b1;
        step();
        n_cmp++;
        if (leds4 !== 8'd9 || sel4 !== 2'd1) begin
            n_bad++;
            $display("FAIL show_winner leds=%0d sel=%0d need 9/1", leds4, sel4);
        end
        sw4 = 1'b0;
        m4  = 1'b0;
        step();
        n_cmp++;
        if (leds4 !== 8'h00 || {wv4, tie4, busy4} !== 3'b000) begin
            n_bad++;
            $display("FAIL mode_exit leds=%h wv=%b tie=%b busy=%b need 0",
                     leds4, wv4, tie4, busy4);
        end
    endtask

    task automatic test_buttons();
        mc4 = '{2, 7, 5, 1};
        load4();
        m4 = 1'b1;
        repeat (6) step();
        btn4 = 4'b1100;
        step();
        n_cmp++;
        if (leds4 !== 8'd5 || sel4 !== 2'd2) begin
            n_bad++;
            $display("FAIL btn_1100 leds=%0d sel=%0d need 5/2", leds4, sel4);
        end
        btn4 = 4'b0001;
        step();
        n_cmp++;
        if (leds4 !== 8'd2 || sel4 !== 2'd0) begin
            n_bad++;
            $display("FAIL btn_0001 leds=%0d sel=%0d need 2/0", leds4, sel4);
        end
        btn4 = 4'b0000;
        v4   = 1'b1;
        step();
        v4 = 1'b0;
        n_cmp++;
        if (leds4 !== 8'd2 || wv4 !== 1'b1) begin
            n_bad++;
            $display("FAIL hold_ignore_vote leds=%0d wv=%b need 2/1", leds4, wv4);
        end
        sw4 = 1'b1;
        step();
        n_cmp++;
        if (leds4 !== 8'd7 || sel4 !== 2'd1) begin
            n_bad++;
            $display("FAIL btn_winner leds=%0d sel=%0d need 7/1", leds4, sel4);
        end
        sw4 = 1'b0;
        m4  = 1'b0;
        step();
    endtask

    task automatic test_random_scan();
        int mx, wi, li;
        bit et, got, upd;
        logic [7:0] eled;
        for (int it = 0; it < 10; it++) begin
            mc4 = {};
            for (int i = 0; i < 4; i++)
                mc4.push_back(it < 5 ? $urandom_range(0, 3) : $urandom_range(0, 255));
            load4();
            ref_scan(mc4, mx, wi, et);
            m4  = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 12 && !got; c++) begin
                step();
                got = wv4;
            end
            n_cmp++;
            if (!got) begin
                n_bad++;
                $display("FAIL rscan_timeout it=%0d wv=%b need 1", it, wv4);
            end
            n_cmp++;
            if (widx4 !== 2'(wi) || tie4 !== et) begin
                n_bad++;
                $display("FAIL rscan it=%0d widx=%0d tie=%b need %0d/%b",
                         it, widx4, tie4, wi, et);
            end
            eled = 8'h00;
            for (int k = 0; k < 6; k++) begin
                btn4 = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
                sw4  = 1'($urandom_range(0, 1));
                step();
                upd = 1'b1;
                li  = low_bit(int'(btn4));
                if (li >= 0) begin
                    eled = 8'(mc4[li]);
                end else if (sw4) begin
                    eled = 8'(mx);
                    li   = wi;
                end else begin
                    upd = 1'b0;
                end
                n_cmp++;
                if (leds4 !== eled || (upd && sel4 !== 2'(li))) begin
                    n_bad++;
                    $display("FAIL rdisp it=%0d k=%0d leds=%0d sel=%0d need %0d/%0d",
                             it, k, leds4, sel4, eled, li);
                end
            end
            btn4 = 4'h0;
            sw4  = 1'b0;
            m4   = 1'b0;
            step();
            n_cmp++;
            if (leds4 !== 8'h00 || wv4 !== 1'b0 || tie4 !== 1'b0) begin
                n_bad++;
                $display("FAIL rexit it=%0d leds=%h wv=%b tie=%b need 0",
                         it, leds4, wv4, tie4);
            end
        end
    endtask

    task automatic test_abort();
        mc4 = '{5, 5, 1, 2};
        load4();
        m4 = 1'b1;
        step();
        step();
        step();
        m4 = 1'b0;
        step();
        n_cmp++;
        if (wv4 !== 1'b0 || leds4 !== 8'h00 || busy4 !== 1'b0 || tie4 !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_scan wv=%b leds=%h busy=%b tie=%b need 0",
                     wv4, leds4, busy4, tie4);
        end
        m4 = 1'b1;
        step();
        m4 = 1'b0;
        repeat (6) step();
        n_cmp++;
        if (wv4 !== 1'b0 || busy4 !== 1'b0) begin
            n_bad++;
            $display("FAIL short_toggle wv=%b busy=%b need 0/0", wv4, busy4);
        end
        v4 = 1'b1;
        step();
        v4 = 1'b0;
        step();
        m4 = 1'b1;
        step();
        n_cmp++;
        if (leds4 !== 8'h00 || busy4 !== 1'b1) begin
            n_bad++;
            $display("FAIL confirm_to_scan leds=%h busy=%b need 00/1", leds4, busy4);
        end
        m4 = 1'b0;
        step();
        repeat (2) step();
        v4 = 1'b1;
        step();
        v4 = 1'b0;
        step();
        n_cmp++;
        if (leds4 !== 8'hFF) begin
            n_bad++;
            $display("FAIL pre_reset_confirm leds=%h need FF", leds4);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (leds4 !== 8'h00 || busy4 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_confirm leds=%h busy=%b need 00/0",
                     leds4, busy4);
        end
        #2 reset = 1'b0;
        step();
        n_cmp++;
        if (leds4 !== 8'h00) begin
            n_bad++;
            $display("FAIL post_reset_confirm leds=%h need 00", leds4);
        end
        m4 = 1'b1;
        step();
        step();
        n_cmp++;
        if (busy4 !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_scan_busy busy=%b need 1", busy4);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (busy4 !== 1'b0 || widx4 !== 2'd0 || tie4 !== 1'b0 || wv4 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_reset_scan busy=%b widx=%0d tie=%b wv=%b need 0",
                     busy4, widx4, tie4, wv4);
        end
        m4 = 1'b0;
        #2 reset = 1'b0;
        repeat (7) step();
        n_cmp++;
        if (wv4 !== 1'b0 || busy4 !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset_scan wv=%b busy=%b need 0/0", wv4, busy4);
        end
    endtask

    task automatic test_wide();
        int mx, wi, li;
        bit et, got;
        for (int it = 0; it < 3; it++) begin
            mc8 = {};
            for (int i = 0; i < 8; i++)
                mc8.push_back(it == 0 ? 12'h0FF : $urandom_range(0, 4095));
            load8();
            ref_scan(mc8, mx, wi, et);
            m8  = 1'b1;
            got = 1'b0;
            for (int c = 0; c < 16 && !got; c++) begin
                step();
                got = wv8;
            end
            n_cmp++;
            if (!got || widx8 !== 3'(wi) || tie8 !== et) begin
                n_bad++;
                $display("FAIL wide_scan it=%0d wv=%b widx=%0d tie=%b need 1/%0d/%b",
                         it, wv8, widx8, tie8, wi, et);
            end
            btn8 = (it == 0) ? 8'h80 : 8'($urandom_range(1, 255));
            li   = low_bit(int'(btn8));
            step();
            n_cmp++;
            if (leds8 !== 12'(mc8[li]) || sel8 !== 3'(li)) begin
                n_bad++;
                $display("FAIL wide_btn it=%0d leds=%h sel=%0d need %h/%0d",
                         it, leds8, sel8, mc8[li], li);
            end
            btn8 = 8'h00;
            m8   = 1'b0;
            step();
        end
        v8 = 1'b1;
        step();
        v8 = 1'b0;
        for (int k = 0; k < C8; k++) begin
            n_cmp++;
            if (leds8 !== 12'hFFF) begin
                n_bad++;
                $display("FAIL wide_confirm k=%0d leds=%h need FFF", k, leds8);
            end
            step();
        end
        n_cmp++;
        if (leds8 !== 12'h000) begin
            n_bad++;
            $display("FAIL wide_confirm_end leds=%h need 000", leds8);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_confirm();
        test_scan_fixed();
        test_buttons();
        test_random_scan();
        test_abort();
        test_wide();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
